axis_register_slice: RTL



---
 rtl/axis_register_slice.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axis_register_slice.sv
// axis_register_slice: STAGES cascaded valid/ready skid-buffer stages.
// Every stage registers data, valid and ready, so long stream paths can be
// pipelined without losing throughput. STAGES=0 gives a combinational wire.
// Optional build macro: AXIS_REGISTER_SLICE_STALL_CNT_EN adds the stall_cnt
// port, a saturating count of cycles with m_valid=1 and m_ready=0.
module axis_register_slice #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned STAGES          = 1,
   parameter int unsigned STALL_CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic                       m_valid,
   input  logic                       m_ready
`ifdef AXIS_REGISTER_SLICE_STALL_CNT_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   generate
      if (DATA_WIDTH < 1) begin : g_bad_data_width
         $error("axis_register_slice: DATA_WIDTH must be >= 1");
      end
      if (STAGES > 8) begin : g_bad_stages
         $error("axis_register_slice: STAGES must be 0..8");
      end
      if (STALL_CNT_WIDTH < 1) begin : g_bad_stall_width
         $error("axis_register_slice: STALL_CNT_WIDTH must be >= 1");
      end
   endgenerate

   generate
      if (STAGES == 0) begin : g_wire
         assign m_data  = s_data;
         assign m_valid = s_valid;
         assign s_ready = m_ready;
      end else begin : g_pipe
         // Index k is the input side of stage k; index STAGES is the m_* side.
         logic [DATA_WIDTH-1:0] ch_data [STAGES+1];
         logic [STAGES:0]       ch_valid;
         logic [STAGES:0]       ch_ready;

         assign ch_data[0]       = s_data;
         assign ch_valid[0]      = s_valid;
         assign s_ready          = ch_ready[0];
         assign m_data           = ch_data[STAGES];
         assign m_valid          = ch_valid[STAGES];
         assign ch_ready[STAGES] = m_ready;

         for (genvar k = 0; k < STAGES; k++) begin : g_stage
            stage_state_e          state_q, state_d;
            logic [DATA_WIDTH-1:0] main_q, main_d;
            logic [DATA_WIDTH-1:0] skid_q, skid_d;
            logic                  rdy_q;
            logic                  in_fire;
            logic                  out_fire;

            assign in_fire  = ch_valid[k] & rdy_q;
            assign out_fire = (state_q != ST_EMPTY) & ch_ready[k+1];

            // Next state: main register feeds the output, skid catches the
            // one word that can arrive while the output is stalled.
            always_comb begin
               state_d = state_q;
               main_d  = main_q;
               skid_d  = skid_q;
               case (state_q)
                  ST_EMPTY: begin
                     if (in_fire) begin
                        main_d  = ch_data[k];
                        state_d = ST_BUSY;
                     end
                  end
                  ST_BUSY: begin
                     if (out_fire && in_fire) begin
                        main_d = ch_data[k];
                     end else if (out_fire) begin
                        state_d = ST_EMPTY;
                     end else if (in_fire) begin
                        skid_d  = ch_data[k];
                        state_d = ST_FULL;
                     end
                  end
                  ST_FULL: begin
                     if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                     end
                  end
                  default: state_d = ST_EMPTY;
               endcase
            end

            // Stage registers; ready is held low during reset and rises on
            // the first clock after reset is released.
            always_ff @(posedge clk) begin
               if (rst) begin
                  state_q <= ST_EMPTY;
                  main_q  <= '0;
                  skid_q  <= '0;
                  rdy_q   <= 1'b0;
               end else begin
                  state_q <= state_d;
                  main_q  <= main_d;
                  skid_q  <= skid_d;
                  rdy_q   <= (state_d != ST_FULL);
               end
            end

            assign ch_ready[k]   = rdy_q;
            assign ch_valid[k+1] = (state_q != ST_EMPTY);
            assign ch_data[k+1]  = main_q;
         end
      end
   endgenerate

`ifdef AXIS_REGISTER_SLICE_STALL_CNT_EN
   logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

   // Saturating stall count: holds at all-ones instead of wrapping.
   always_comb begin
      stall_d = stall_q;
      if (m_valid && !m_ready && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
